uart_rx_fifo: RTL and testbench

//  Byte FIFO directly downstream of the UART receiver. Captures each received byte
//  (dataOut, qualified by the one-cycle finished_read pulse) and holds it until

---
 rtl/uart_rx_fifo.sv | 70 +++++++
 tb/tb_uart_rx_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: show-ahead read port, count-decoded status
// flags and a sticky overflow flag for bytes dropped while full.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     overflow_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;
    logic          drop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    always_comb begin
        empty       = (count == '0);
        full        = (count == FULL_CNT);
        almost_full = (count >= AF_CNT);
        pop_ok      = rd_en && !empty;
        push_ok     = rx_valid && (!full || pop_ok);
        drop        = rx_valid && full && !pop_ok;
        rd_data     = empty ? 8'h00 : mem[rd_ptr];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new drop wins over a clear requested in the same cycle.
            if (drop)                overflow <= 1'b1;
            else if (overflow_clear) overflow <= 1'b0;
        end
    end

    // NOTE: storage has no reset; pointers and count alone decide what is valid,
    // so the array maps onto plain RAM without a clear path.
    always_ff @(posedge clock) begin
        if (!reset && push_ok) mem[wr_ptr] <= rx_data;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_rx_fifo;

    localparam int DEPTH       = 16;
    localparam int ALMOST_FULL = 12;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rd_en = 1'b0;
    logic       overflow_clear = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    logic [7:0] model_q [$];
    logic       model_ovf = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .ALMOST_FULL(ALMOST_FULL)) dut (
        .clock          (clock),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .empty          (empty),
        .full           (full),
        .almost_full    (almost_full),
        .count          (count),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of held bytes plus the sticky drop flag.
    always @(posedge clock) begin
        bit pop;
        bit drop;
        if (reset) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            pop  = rd_en && (model_q.size() > 0);
            drop = rx_valid && (model_q.size() == DEPTH) && !pop;
            if (pop) void'(model_q.pop_front());
            if (rx_valid && !drop) model_q.push_back(rx_data);
            if (drop) model_ovf = 1'b1;
            else if (overflow_clear) model_ovf = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (check_en) begin
            check("model_count",  32'(count),       32'(model_q.size()));
            check("model_empty",  32'(empty),       32'(model_q.size() == 0));
            check("model_full",   32'(full),        32'(model_q.size() == DEPTH));
            check("model_afull",  32'(almost_full), 32'(model_q.size() >= ALMOST_FULL));
            check("model_ovf",    32'(overflow),    32'(model_ovf));
            check("model_rddata", 32'(rd_data),     32'(model_q.size() > 0 ? model_q[0] : 8'h00));
        end
    end

    // One clock cycle with the given inputs; called and returning at a negedge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic c);
        rx_valid       = v;
        rx_data        = d;
        rd_en          = r;
        overflow_clear = c;
        @(negedge clock);
        rx_valid       = 1'b0;
        rd_en          = 1'b0;
        overflow_clear = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        @(negedge clock);
        @(negedge clock);
        reset    = 1'b0;
        check_en = 1'b1;
        check("rst_empty", 32'(empty),   32'd1);
        check("rst_count", 32'(count),   32'd0);
        check("rst_rd",    32'(rd_data), 32'h00);
        check("rst_full",  32'(full),    32'd0);

        // 1: single byte round trip
        cyc(1, 8'hA5, 0, 0);
        check("s1_empty", 32'(empty),   32'd0);
        check("s1_count", 32'(count),   32'd1);
        check("s1_rd",    32'(rd_data), 32'hA5);
        cyc(0, 8'h00, 1, 0);
        check("s1_pop_empty", 32'(empty),   32'd1);
        check("s1_pop_rd",    32'(rd_data), 32'h00);
        check("s1_pop_count", 32'(count),   32'd0);

        // 2: fill, drain in order, wrap
        for (int i = 0; i < 16; i++) begin
            cyc(1, 8'(i), 0, 0);
            check("s2_afull", 32'(almost_full), 32'(i + 1 >= 12));
        end
        check("s2_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("s2_order", 32'(rd_data), 32'(i));
            cyc(0, 8'h00, 1, 0);
        end
        check("s2_drained", 32'(empty), 32'd1);
        cyc(1, 8'h42, 0, 0);
        check("s2_wrap_rd", 32'(rd_data), 32'h42);
        cyc(0, 8'h00, 1, 0);

        // 3: overflow, clear, clear+drop
        for (int i = 0; i < 16; i++) cyc(1, 8'h80 + 8'(i), 0, 0);
        cyc(1, 8'hEE, 0, 0);
        check("s3_ovf",   32'(overflow), 32'd1);
        check("s3_count", 32'(count),    32'd16);
        check("s3_head",  32'(rd_data),  32'h80);
        cyc(0, 8'h00, 0, 1);
        check("s3_clear", 32'(overflow), 32'd0);
        cyc(1, 8'hEE, 0, 1);
        check("s3_set_wins", 32'(overflow), 32'd1);
        cyc(0, 8'h00, 0, 1);
        for (int i = 0; i < 16; i++) begin
            check("s3_drain", 32'(rd_data), 32'(8'h80 + 8'(i)));
            cyc(0, 8'h00, 1, 0);
        end

        // 4: push with pop while full
        for (int i = 0; i < 16; i++) cyc(1, 8'h10 + 8'(i), 0, 0);
        cyc(1, 8'h77, 1, 0);
        check("s4_count", 32'(count),    32'd16);
        check("s4_ovf",   32'(overflow), 32'd0);
        check("s4_head",  32'(rd_data),  32'h11);
        for (int i = 0; i < 16; i++) begin
            b = (i == 15) ? 8'h77 : 8'h11 + 8'(i);
            check("s4_drain", 32'(rd_data), 32'(b));
            cyc(0, 8'h00, 1, 0);
        end

        // 5: push with pop while empty, then pop on empty
        cyc(1, 8'h31, 1, 0);
        check("s5_count", 32'(count),   32'd1);
        check("s5_rd",    32'(rd_data), 32'h31);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        check("s5_idle_count", 32'(count), 32'd0);
        check("s5_idle_empty", 32'(empty), 32'd1);

        // 6: reset mid-operation with a push in the reset cycle
        for (int i = 0; i < 5; i++) cyc(1, 8'h50 + 8'(i), 0, 0);
        check("s6_pre_count", 32'(count), 32'd5);
        reset = 1'b1;
        cyc(1, 8'h99, 0, 0);
        reset = 1'b0;
        check("s6_count", 32'(count),    32'd0);
        check("s6_empty", 32'(empty),    32'd1);
        check("s6_ovf",   32'(overflow), 32'd0);
        check("s6_rd",    32'(rd_data),  32'h00);
        cyc(1, 8'h5A, 0, 0);
        check("s6_after_rd",    32'(rd_data), 32'h5A);
        check("s6_after_count", 32'(count),   32'd1);

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
